// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder controller and its adder datapath.
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble index register; kept at least one bit wide.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/fourbit_adder.sv
// Combinational 4-bit ripple-carry adder that sits beside the serial controller.
module fourbit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end

endmodule

// File: rtl/serial_nibble_adder.sv
// Adds two NIBBLES*4-bit operands by stepping them one nibble per clock through an
// external 4-bit adder, with a start/ready/done handshake around the operation.
module serial_nibble_adder
    import adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [NIBBLE_W*NIBBLES-1:0]  op_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  op_b,
    input  logic                         cin,
    output logic                         ready,
    output logic [NIBBLE_W-1:0]          add_a,
    output logic [NIBBLE_W-1:0]          add_b,
    output logic                         add_cin,
    input  logic [NIBBLE_W-1:0]          add_s,
    input  logic                         add_cout,
    output logic [NIBBLE_W*NIBBLES-1:0]  sum,
    output logic                         cout,
    output logic                         overflow,
    output logic                         done,
    output state_t                       dbg_state
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = idx_width(NIBBLES);

    // Handshake: a request is taken on a rising edge where start && ready; ready is
    // high only in IDLE, so start during RUN/DONE is dropped, never queued. done is a
    // single-cycle pulse, and sum/cout/overflow are valid in that cycle and held after.

    state_t         state, state_nxt;
    logic [W-1:0]   opa, opb, partial, partial_nxt;
    logic           carry;
    logic [IW-1:0]  idx;
    logic           last;
    int unsigned    base;

    always_comb begin
        state_nxt   = state;
        add_a       = '0;
        add_b       = '0;
        add_cin     = 1'b0;
        base        = NIBBLE_W * int'(idx);
        last        = (idx == IW'(NIBBLES - 1));
        partial_nxt = partial;
        partial_nxt[base +: NIBBLE_W] = add_s;

        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                add_a   = opa[base +: NIBBLE_W];
                add_b   = opb[base +: NIBBLE_W];
                add_cin = carry;
                if (last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ready     = (state == IDLE);
    assign done      = (state == DONE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            opa      <= '0;
            opb      <= '0;
            partial  <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                opa     <= op_a;
                opb     <= op_b;
                carry   <= cin;
                idx     <= '0;
                partial <= '0;
            end else if (state == RUN) begin
                partial <= partial_nxt;
                carry   <= add_cout;
                if (last) begin
                    idx      <= '0;
                    // Results change only here, so they never expose a partial sum.
                    sum      <= partial_nxt;
                    cout     <= add_cout;
                    overflow <= (opa[W-1] == opb[W-1]) && (add_s[NIBBLE_W-1] != opa[W-1]);
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Bench for serial_nibble_adder wired to fourbit_adder: a cycle-level reference model
// checked every cycle, plus directed operations with literal expected results.
module tb_serial_nibble_adder;
    import adder_pkg::*;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         ready, add_cin, add_cout, cout, overflow, done;
    logic [3:0]   add_a, add_b, add_s;
    logic [W-1:0] sum;
    state_t       dbg_state;

    int checks = 0;
    int errors = 0;

    serial_nibble_adder #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
        .ready(ready), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout), .sum(sum), .cout(cout),
        .overflow(overflow), .done(done), .dbg_state(dbg_state)
    );

    fourbit_adder u_add (
        .a(add_a), .b(add_b), .cin(add_cin), .s(add_s), .cout(add_cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Carry entering nibble i, from plain arithmetic on the low 4*i bits.
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c, input int i);
        logic [W:0] mask, t;
        mask = ((W+1)'(1) << (4 * i)) - 1'b1;
        t    = ({1'b0, a} & mask) + ({1'b0, b} & mask) + (W+1)'(c);
        return t[4 * i];
    endfunction

    // Reference model: phase 0 idle, 1..N nibble cycles, N+1 done cycle.
    int           phase = 0;
    logic [W-1:0] ma = '0, mb = '0, m_sum = '0;
    logic         mc = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
    logic [W:0]   m_total;

    assign m_total = {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 0; ma <= '0; mb <= '0; mc <= 1'b0;
            m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
        end else if (phase == 0) begin
            if (start) begin
                phase <= 1; ma <= op_a; mb <= op_b; mc <= cin;
            end
        end else if (phase == N) begin
            m_sum  <= m_total[W-1:0];
            m_cout <= m_total[W];
            m_ovf  <= (ma[W-1] == mb[W-1]) && (m_total[W-1] != ma[W-1]);
            phase  <= N + 1;
        end else if (phase == N + 1) begin
            phase <= 0;
        end else begin
            phase <= phase + 1;
        end
    end

    always @(negedge clk) begin
        logic [3:0]   e_a, e_b;
        logic         e_cin;
        logic [1:0]   e_st;
        logic [W-1:0] sa, sb;
        e_a = '0; e_b = '0; e_cin = 1'b0;
        e_st = (phase == 0) ? 2'(IDLE) : (phase <= N) ? 2'(RUN) : 2'(DONE);
        if (phase >= 1 && phase <= N) begin
            sa    = ma >> (4 * (phase - 1));
            sb    = mb >> (4 * (phase - 1));
            e_a   = sa[3:0];
            e_b   = sb[3:0];
            e_cin = carry_into(ma, mb, mc, phase - 1);
        end
        chk("ready", (W+1)'(ready), (W+1)'(phase == 0));
        chk("done", (W+1)'(done), (W+1)'(phase == N + 1));
        chk("state", (W+1)'(dbg_state), (W+1)'(e_st));
        chk("add_a", (W+1)'(add_a), (W+1)'(e_a));
        chk("add_b", (W+1)'(add_b), (W+1)'(e_b));
        chk("add_cin", (W+1)'(add_cin), (W+1)'(e_cin));
        chk("sum", (W+1)'(sum), (W+1)'(m_sum));
        chk("cout", (W+1)'(cout), (W+1)'(m_cout));
        chk("overflow", (W+1)'(overflow), (W+1)'(m_ovf));
    end

    // Raise start with operands; returns 2 time units after the accepting edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        @(posedge clk); #2;
        start = 1'b1; op_a = a; op_b = b; cin = c;
        @(posedge clk); #2;
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        cin   = 1'($urandom_range(0, 1));
    endtask

    // Waits (bounded) for done; k is the count of negedges seen, done-cycle included.
    task automatic wait_result(input string name, input logic [W-1:0] es,
                               input logic ec, input logic eo, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 20);
        chk({name, "_done_seen"}, (W+1)'(done), (W+1)'(1));
        chk({name, "_sum"}, (W+1)'(sum), (W+1)'(es));
        chk({name, "_cout"}, (W+1)'(cout), (W+1)'(ec));
        chk({name, "_ovf"}, (W+1)'(overflow), (W+1)'(eo));
        @(negedge clk);
        chk({name, "_done_one_cycle"}, (W+1)'(done), (W+1)'(0));
    endtask

    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic [W-1:0] es, input logic ec, input logic eo);
        int k;
        launch(a, b, c);
        wait_result(name, es, ec, eo, k);
        chk({name, "_latency"}, (W+1)'(k - 1), (W+1)'(N));
    endtask

    initial begin
        int k, ndone, quiet;
        int at[$];

        repeat (2) @(posedge clk);
        #2;
        chk("rst_ready", (W+1)'(ready), (W+1)'(1));
        chk("rst_sum", (W+1)'(sum), (W+1)'(0));
        chk("rst_done", (W+1)'(done), (W+1)'(0));
        rst_n = 1'b1;

        do_op("add_5555", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("neg_ovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        do_op("cin_in", 16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0);

        // start pulsed mid-RUN with different operands must be ignored
        launch(16'h1234, 16'h4321, 1'b0);
        #3;
        start = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555; cin = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_result("ignored_start", 16'h5555, 1'b0, 1'b0, k);

        // reset during the second RUN cycle aborts and discards the old result
        launch(16'hFFFF, 16'hFFFF, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_sum", (W+1)'(sum), (W+1)'(0));
        chk("abort_ready", (W+1)'(ready), (W+1)'(1));
        @(posedge clk); #2;
        rst_n = 1'b1;
        quiet = 0;
        repeat (N + 3) begin
            @(negedge clk);
            if (done) quiet++;
        end
        chk("abort_no_done", (W+1)'(quiet), (W+1)'(0));
        do_op("after_abort", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);

        // start held high for 20 cycles: one accept per IDLE visit
        @(posedge clk); #2;
        start = 1'b1; op_a = 16'h1111; op_b = 16'h2222; cin = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                at.push_back(i);
                chk("held_sum", (W+1)'(sum), (W+1)'(16'h3333));
            end
        end
        @(posedge clk); #2;
        start = 1'b0;
        chk("held_pulses", (W+1)'(ndone), (W+1)'(3));
        for (int i = 1; i < at.size(); i++)
            chk("held_spacing", (W+1)'(at[i] - at[i-1]), (W+1)'(N + 2));
        repeat (2 * N + 4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_nibble_adder.md
# serial_nibble_adder

Multi-nibble adder controller that adds two `4*NIBBLES`-bit operands by sequencing them through the existing combinational 4-bit ripple adder one nibble per clock. It sits directly around that adder:
- upstream, it drives the adder's A, B and Cin inputs;
- downstream, it captures the adder's S and Cout outputs.

The inter-nibble carry is kept in a register. Results are returned with a start/ready/done handshake.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices. Operand width `W = 4*NIBBLES`. Legal range is ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: request. Sampled only when `ready` = 1.
- `op_a` in W: operand A. Captured on the accepted `start`.
- `op_b` in W: operand B. Captured on the accepted `start`.
- `cin` in 1: carry-in into nibble 0. Captured on the accepted `start`.
- `ready` out 1: high in IDLE only.
- `add_a` out 4: to adder A3..A0.
- `add_b` out 4: to adder B3..B0.
- `add_cin` out 1: to adder Cin.
- `add_s` in 4: from adder S3..S0.
- `add_cout` in 1: from adder Cout.
- `sum` out W: result.
- `cout` out 1: unsigned carry-out.
- `overflow` out 1: two's-complement overflow.
- `done` out 1: one-cycle result-valid pulse.

## Operation
- States and transitions:
  - IDLE → RUN on `start` with `ready` = 1.
  - RUN → DONE after the nibble with index `NIBBLES-1` is captured.
  - DONE → IDLE unconditionally.
- On accept:
  - latch `op_a`, `op_b` into operand registers;
  - set carry register to `cin`;
  - set nibble index `idx` to 0.
- RUN, each cycle:
  - Drive the adder combinationally:
    - `add_a` = `opa[4*idx +: 4]`
    - `add_b` = `opb[4*idx +: 4]`
    - `add_cin` = carry register
  - At the clock edge:
    - `partial[4*idx +: 4]` ← `add_s`
    - carry ← `add_cout`
    - `idx` ← `idx+1`
- On the final nibble edge, update in the same edge:
  - `sum` ← full partial result including the last nibble;
  - `cout` ← `add_cout`;
  - `overflow` ← (`opa[W-1]` == `opb[W-1]`) && (`add_s[3]` != `opa[W-1]`).
- DONE: `done` = 1 for exactly one cycle.
- `sum`, `cout`, `overflow` hold their values until the next result's final edge. They never show partial values.
- Outside RUN, `add_a`, `add_b` and `add_cin` are driven to 0.
- Arithmetic: unsigned modulo 2^W. `cout` is bit W of `op_a + op_b + cin`.

## Timing
- Reset values:
  - state IDLE
  - `ready` 1
  - `done` 0
  - `sum` 0
  - `cout` 0
  - `overflow` 0
  - `add_a`, `add_b`, `add_cin` 0
  - `idx` 0
  - carry 0
- Latency:
  - `start` accepted at edge E.
  - Nibbles are captured at edges E+1 … E+NIBBLES.
  - `done` is high during cycle E+NIBBLES … E+NIBBLES+1, with results valid in that cycle.
  - `ready` returns to 1 after edge E+NIBBLES+1.
  - Throughput is one operation per `NIBBLES`+2 cycles.
- `start` while `ready` = 0 (RUN or DONE) is ignored; it is not queued.
- `op_a`, `op_b`, `cin` may change freely after the accepting edge.
- The adder path (`add_a`/`add_b`/`add_cin` → `add_s`/`add_cout`) is purely combinational and must settle within one clock period.
- `rst_n` asserted mid-RUN or in DONE:
  - immediate abort;
  - all outputs go to reset values;
  - no `done` pulse;
  - the previous result is discarded.
- `start` held high continuously is accepted once per IDLE visit.

## Structure
- Shared package `adder_pkg` holds:
  - `NIBBLE_W` = 4;
  - state enum {IDLE, RUN, DONE};
  - the index-width helper `$clog2(NIBBLES)`.
- No sub-module inside the block. The 4-bit adder (`fourbit_adder`) is instantiated beside it in the enclosing top and wired through the `add_*` ports.
- The bench instantiates `serial_nibble_adder` plus `fourbit_adder`. Bit-to-port mapping is `add_a[i]` → Ai, and likewise for B and S.

## Test plan
All scenarios use `NIBBLES` = 4.
- 0x1234 + 0x4321, `cin` 0 → `sum` 0x5555, `cout` 0, `overflow` 0. `done` is high exactly one cycle, 4 edges after accept.
- 0xFFFF + 0x0001, `cin` 0 → `sum` 0x0000, `cout` 1, `overflow` 0. The carry propagates through all nibbles, and `add_cin` = 1 for nibbles 1–3.
- 0x7FFF + 0x0001 → `sum` 0x8000, `cout` 0, `overflow` 1. Then 0x8000 + 0x8000 → `sum` 0x0000, `cout` 1, `overflow` 1.
- 0x0F0F + 0x00F1, `cin` 1 → `sum` 0x1001, `cout` 0. `sum` holds the previous value 0x0000 until the final edge.
- Pulse `start` with new operands during RUN → ignored, and the first result completes unchanged. Then assert `rst_n` low in RUN cycle 2 → outputs reset, no `done`. A following 0x0001 + 0x0002 → `sum` 0x0003.
- Hold `start` high for 20 cycles with fixed operands → exactly 3 `done` pulses spaced 6 cycles apart, each with the identical result.
